shift_register_n: RTL



---
 rtl/shift_register_n_pkg.sv | 30 +++
 rtl/shift_register_n_stage.sv | 36 +++
 rtl/shift_register_n.sv | 103 ++++++++++
 3 files changed

// File: rtl/shift_register_n_pkg.sv
// Shared constants and types for the universal shift register.
// Mode/direction encodings plus the per-stage next-value select.
package shift_register_n_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_NBR  = 2'b01,
        SEL_LOAD = 2'b10
    } stage_sel_e;

    // Shift and rotate both take the neighbour; only the end-stage insert differs.
    function automatic stage_sel_e mode_to_sel(input logic [1:0] mode);
        stage_sel_e sel;
        case (mode)
            MODE_SHIFT, MODE_ROTATE: sel = SEL_NBR;
            MODE_LOAD:               sel = SEL_LOAD;
            default:                 sel = SEL_HOLD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/shift_register_n_stage.sv
// One WIDTH-bit stage of the shift register: synchronous clear, enable,
// and a hold / neighbour / parallel-load next-value mux.
module shift_stage
    import shift_register_n_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  stage_sel_e       sel,
    input  logic [WIDTH-1:0] nbr,
    input  logic [WIDTH-1:0] ld,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d_c;

    always_comb begin
        d_c = q;
        case (sel)
            SEL_NBR:  d_c = nbr;
            SEL_LOAD: d_c = ld;
            default:  d_c = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d_c;
        end
    end

endmodule

// File: rtl/shift_register_n.sv
// Parametrised universal shift register: hold, shift, rotate and parallel load
// in either direction, with a saturating fill counter and registered full flag.
module shift_register_n
    import shift_register_n_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 5
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       dir,
    input  logic [WIDTH-1:0]           sin,
    input  logic [DEPTH*WIDTH-1:0]     pin,
    output logic [DEPTH*WIDTH-1:0]     pout,
    output logic [WIDTH-1:0]           sout,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       full
);

    localparam int unsigned FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic [WIDTH-1:0]  stage_q [DEPTH];
    logic [WIDTH-1:0]  outgoing_c;
    logic [WIDTH-1:0]  insert_c;
    logic              stage_en_c;
    stage_sel_e        sel_c;
    logic [FILL_W-1:0] fill_nxt_c;
    logic              full_nxt_c;

    // The element leaving the chain doubles as sout and the rotate insert.
    always_comb begin
        outgoing_c = (dir == DIR_DOWN) ? stage_q[0] : stage_q[DEPTH-1];
        insert_c   = (mode == MODE_ROTATE) ? outgoing_c : sin;
        stage_en_c = en && (mode != MODE_HOLD);
        sel_c      = mode_to_sel(mode);
    end

    assign sout = outgoing_c;

    for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
        logic [WIDTH-1:0] nbr_c;

        if (k == 0) begin : g_lo
            always_comb nbr_c = (dir == DIR_UP) ? insert_c : stage_q[k+1];
        end else if (k == int'(DEPTH) - 1) begin : g_hi
            always_comb nbr_c = (dir == DIR_UP) ? stage_q[k-1] : insert_c;
        end else begin : g_mid
            always_comb nbr_c = (dir == DIR_UP) ? stage_q[k-1] : stage_q[k+1];
        end

        shift_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk (clk),
            .clr (clr),
            .en  (stage_en_c),
            .sel (sel_c),
            .nbr (nbr_c),
            .ld  (pin[k*WIDTH +: WIDTH]),
            .q   (stage_q[k])
        );

        assign pout[k*WIDTH +: WIDTH] = stage_q[k];
    end

    // Shift saturates at DEPTH, load fills instantly, rotate and hold keep the count.
    always_comb begin
        fill_nxt_c = fill;
        full_nxt_c = full;
        if (en) begin
            case (mode)
                MODE_SHIFT: begin
                    if (fill != FILL_MAX) begin
                        fill_nxt_c = fill + FILL_W'(1);
                        full_nxt_c = (fill == FILL_MAX - FILL_W'(1));
                    end
                end
                MODE_LOAD: begin
                    fill_nxt_c = FILL_MAX;
                    full_nxt_c = 1'b1;
                end
                default: begin
                    fill_nxt_c = fill;
                    full_nxt_c = full;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            fill <= '0;
            full <= 1'b0;
        end else begin
            fill <= fill_nxt_c;
            full <= full_nxt_c;
        end
    end

endmodule
